serial_arbiter: RTL and testbench

- Shares one serial transmit path (byte stream into the UART transmitter) between N byte-stream requesters.
- Round-robin arbitration; grant locked for a whole packet (until `s_last`), with a per-grant byte limit so a stuck requester cannot starve the others.
- Sits between host-side stream producers and the `transmit` block, on the same `clk` domain as `receive`/`transmit`.

---
 rtl/serial_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_serial_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_arbiter.sv
// ---------------------------------------------------------------------------
// serial_arbiter
//
// Shares one byte stream (into the UART transmitter) between N byte-stream
// requesters. Round-robin arbitration; the grant is held for a whole packet
// (until s_last). A per-grant byte limit (MAXLEN) forces a release so a
// requester that never ends its packet cannot starve the others.
//
// Optional feature (compile-time macro SERIAL_ARBITER_TAG_EN):
//   defined   -> a TAG state sits between IDLE and PASS. It emits one header
//                byte {4'hA, grant[3:0]} before the packet. The header is not
//                counted toward MAXLEN. Requires N <= 16.
//   undefined -> IDLE goes straight to PASS and no header byte exists.
//
// Parameters:
//   N       number of requesters (2..16)
//   MAXLEN  maximum bytes forwarded per grant before forced release (1..65535)
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-low reset
//   s_data   requester bytes, requester i on bits [8i+7:8i]
//   s_valid  requester i has a byte
//   s_last   byte on requester i ends its packet
//   s_ready  byte accepted from requester i (only ever the granted one)
//   m_data   registered byte to the transmitter
//   m_valid  m_data valid
//   m_ready  transmitter accepts the byte
//   grant    index of the current or most recent owner
//   busy     a grant is held
//   err      one-cycle pulse when a grant is cut off at MAXLEN bytes
// ---------------------------------------------------------------------------
module serial_arbiter #(
  parameter int N      = 4,
  parameter int MAXLEN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*N-1:0]       s_data,
  input  logic [N-1:0]         s_valid,
  input  logic [N-1:0]         s_last,
  output logic [N-1:0]         s_ready,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [$clog2(N)-1:0] grant,
  output logic                 busy,
  output logic                 err
);

  localparam int GW = $clog2(N);
  localparam int CW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAG   = 2'd1,
    PASS  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_d;
  logic            take;
  logic            out_free;
  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;

`ifdef SERIAL_ARBITER_TAG_EN
  logic            load_tag;
  logic [7:0]      tag_byte;

  assign tag_byte = {4'hA, 4'(grant)};
`endif

  // The output register can take a new byte when it is empty or when its
  // current byte leaves this cycle (one-entry skid stage).
  assign out_free  = !m_valid || m_ready;

  assign sel_valid = s_valid[grant];
  assign sel_last  = s_last[grant];
  assign sel_data  = s_data[{grant, 3'b000} +: 8];

  assign busy      = (state_q != IDLE);

  // Round-robin scan: the first requesting index after the last owner wins,
  // so the last owner itself is considered last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant;
    for (int k = 1; k <= N; k++) begin
      if (!pick_found && s_valid[GW'((int'(grant) + k) % N)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'((int'(grant) + k) % N);
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    grant_d  = grant;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    take     = 1'b0;
    s_ready  = '0;
`ifdef SERIAL_ARBITER_TAG_EN
    load_tag = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
`ifdef SERIAL_ARBITER_TAG_EN
          state_d = TAG;
`else
          state_d = PASS;
`endif
        end
      end
`ifdef SERIAL_ARBITER_TAG_EN
      TAG: begin
        if (out_free) begin
          load_tag = 1'b1;
          state_d  = PASS;
        end
      end
`endif
      PASS: begin
        s_ready[grant] = out_free;
        take           = out_free && sel_valid;
        if (take) begin
          cnt_d = cnt_q + 1'b1;
          if (sel_last) begin
            state_d = DRAIN;
          end else if (cnt_q == CW'(MAXLEN - 1)) begin
            // Limit reached without s_last: cut the packet here; the rest
            // of it competes again as a new packet.
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_free) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant   <= GW'(N - 1);
      cnt_q   <= '0;
      err     <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= 8'h00;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // right-hand side sees the pre-edge value regardless of statement order.
      state_q <= state_d;
      grant   <= grant_d;
      cnt_q   <= cnt_d;
      err     <= err_d;
      if (take) begin
        m_valid <= 1'b1;
        m_data  <= sel_data;
`ifdef SERIAL_ARBITER_TAG_EN
      end else if (load_tag) begin
        m_valid <= 1'b1;
        m_data  <= tag_byte;
`endif
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serial_arbiter
//
// Self-checking bench for serial_arbiter (N=4, MAXLEN=4). A cycle table
// covers the single-requester timing; queue-driven sequences cover
// contention, backpressure, MAXLEN overrun, reset mid-packet and the header
// byte when SERIAL_ARBITER_TAG_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_arbiter;

  localparam int N      = 4;
  localparam int MAXLEN = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [8*N-1:0] s_data;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_last;
  logic [N-1:0]   s_ready;
  logic [7:0]     m_data;
  logic           m_valid;
  logic           m_ready;
  logic [1:0]     grant;
  logic           busy;
  logic           err;

  always #5 clk = ~clk;

  serial_arbiter #(.N(N), .MAXLEN(MAXLEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .grant   (grant),
    .busy    (busy),
    .err     (err)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      req_q [N][$];
  logic [7:0] out_q [$];
  logic [7:0] exp_q [$];
  int         acc_cnt [N];
  int         err_seen;
  int         err_at;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  // Output monitor: collects transferred bytes and checks that a stalled
  // byte stays put until the transmitter takes it.
  always @(posedge clk) begin
    if (!rst) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold m_valid", 32'(m_valid), 32'd1);
        check("hold m_data", 32'(m_data), 32'(hold_data));
      end
      if (m_valid && m_ready) out_q.push_back(m_data);
      hold_prev <= m_valid && !m_ready;
      hold_data <= m_data;
    end
  end

  task automatic push_pkt(input int r, input logic [7:0] base, input int len, input bit last);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = base + 8'(k);
      b.l = last && (k == len - 1);
      req_q[r].push_back(b);
    end
  endtask

  task automatic expect_tag(input int r);
`ifdef SERIAL_ARBITER_TAG_EN
    exp_q.push_back({4'hA, 4'(r)});
`else
    if (r < 0) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic expect_seq(input int r, input logic [7:0] first, input int cnt);
    expect_tag(r);
    for (int k = 0; k < cnt; k++) exp_q.push_back(first + 8'(k));
  endtask

  task automatic compare_out(input string name);
    int n;
    check($sformatf("%s count", name), 32'(out_q.size()), 32'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", name, i), 32'(out_q[i]), 32'(exp_q[i]));
    out_q.delete();
    exp_q.delete();
  endtask

  // Drives requester queues cycle by cycle. Stops when every queue is empty
  // and the output has been idle for 3 cycles, or (stop_r >= 0) once
  // requester stop_r has had stop_cnt bytes accepted.
  task automatic run(input bit rnd_ready, input int stop_r, input int stop_cnt, input int budget);
    int cyc  = 0;
    int idle = 0;
    bit pending;
    logic [N-1:0] take;
    logic [N-1:0] gmask;
    for (int r = 0; r < N; r++) acc_cnt[r] = 0;
    err_seen = 0;
    err_at   = -1;
    while (1) begin
      @(negedge clk);
      pending = 1'b0;
      for (int r = 0; r < N; r++) if (req_q[r].size() != 0) pending = 1'b1;
      if (stop_r >= 0) begin
        if (acc_cnt[stop_r] >= stop_cnt) break;
      end else begin
        idle = (!pending && !m_valid) ? idle + 1 : 0;
        if (idle >= 3) break;
      end
      if (cyc >= budget) begin
        check("run timeout", 32'd0, 32'd1);
        break;
      end
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int r = 0; r < N; r++) begin
        if (req_q[r].size() != 0) begin
          s_valid[r]          = 1'b1;
          s_data[8*r +: 8]    = req_q[r][0].d;
          s_last[r]           = req_q[r][0].l;
        end else begin
          s_valid[r]          = 1'b0;
          s_data[8*r +: 8]    = 8'h00;
          s_last[r]           = 1'b0;
        end
      end
      #2;
      gmask = 4'b0001 << grant;
      check("s_ready legal",
            32'(((s_ready & ~gmask) == '0) && !((|s_ready) && m_valid && !m_ready)), 32'd1);
      if (err) begin
        err_seen++;
        err_at = acc_cnt[0];
      end
      take = s_valid & s_ready;
      @(posedge clk);
      for (int r = 0; r < N; r++) begin
        if (take[r]) begin
          void'(req_q[r].pop_front());
          acc_cnt[r]++;
        end
      end
      cyc++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset s_ready", 32'(s_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset grant", 32'(grant), 32'(N - 1));
    check("reset err", 32'(err), 32'd0);
    check("reset m_data", 32'(m_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Single-requester cycle table: inputs of requester 0 plus m_ready, and
  // the outputs expected in the same cycle.
  typedef struct packed {
    logic       v0;
    logic       l0;
    logic [7:0] d0;
    logic       mr;
    logic       sr0;
    logic       mv;
    logic [7:0] md;
    logic       mdc;
    logic       bz;
    logic [1:0] gr;
    logic       er;
  } vec_t;

`ifdef SERIAL_ARBITER_TAG_EN
  localparam int NV = 8;
`else
  localparam int NV = 7;
`endif

  vec_t tbl [NV];

  initial begin
    logic [7:0] rb [8];
    beat_t      b;

`ifdef SERIAL_ARBITER_TAG_EN
    tbl[0] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
`else
    tbl[0] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
`endif

    rst     = 1'b1;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b1;
    #1 rst  = 1'b0;
    apply_reset();

    // Single requester, cycle by cycle.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      s_valid     = {3'b000, tbl[i].v0};
      s_last      = {3'b000, tbl[i].l0};
      s_data      = '0;
      s_data[7:0] = tbl[i].d0;
      m_ready     = tbl[i].mr;
      #1;
      check($sformatf("vec%0d s_ready", i), 32'(s_ready), {31'd0, tbl[i].sr0});
      check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
      if (tbl[i].mdc) check($sformatf("vec%0d m_data", i), 32'(m_data), 32'(tbl[i].md));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].bz));
      check($sformatf("vec%0d grant", i), 32'(grant), 32'(tbl[i].gr));
      check($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].er));
    end
    @(negedge clk);
    s_valid = '0;
    s_last  = '0;
    out_q.delete();

    // Contention: requesters 1 and 3 at once; 1 wins, no interleaving.
    push_pkt(1, 8'h10, 2, 1'b1);
    push_pkt(3, 8'h30, 2, 1'b1);
    expect_seq(1, 8'h10, 2);
    expect_seq(3, 8'h30, 2);
    run(1'b0, -1, 0, 200);
    compare_out("contend13");

    // All four requesting: rotation 0,1,2,3.
    for (int r = 0; r < N; r++) begin
      push_pkt(r, 8'(8'h80 + 8'(16 * r)), 2, 1'b1);
      expect_seq(r, 8'(8'h80 + 8'(16 * r)), 2);
    end
    run(1'b0, -1, 0, 300);
    compare_out("rotate");
    check("rotate final grant", 32'(grant), 32'd3);
    check("rotate final busy", 32'(busy), 32'd0);

    // Backpressure: 8 random bytes from requester 2 as two MAXLEN-long
    // packets (s_last at exactly MAXLEN is a normal end).
    for (int k = 0; k < 8; k++) begin
      rb[k] = 8'($urandom_range(0, 255));
      b.d   = rb[k];
      b.l   = (k == 3) || (k == 7);
      req_q[2].push_back(b);
      if (k == 0 || k == 4) expect_tag(2);
      exp_q.push_back(rb[k]);
    end
    run(1'b1, -1, 0, 500);
    compare_out("backpressure");
    check("backpressure err", 32'(err_seen), 32'd0);

    // Overrun: requester 0 streams 6 bytes with no s_last, requester 1 waits.
    push_pkt(0, 8'h40, 6, 1'b0);
    push_pkt(1, 8'h50, 2, 1'b1);
    expect_seq(0, 8'h40, 4);
    expect_seq(1, 8'h50, 2);
    expect_seq(0, 8'h44, 2);
    run(1'b0, -1, 0, 300);
    compare_out("overrun");
    check("overrun err pulses", 32'(err_seen), 32'd1);
    check("overrun err position", 32'(err_at), 32'd4);
    check("stalled packet busy", 32'(busy), 32'd1);
    check("stalled packet grant", 32'(grant), 32'd0);

    // Reset in the middle of a 5-byte packet.
    apply_reset();
    push_pkt(1, 8'h60, 5, 1'b1);
    run(1'b0, 1, 2, 100);
    check("pre-reset m_valid", 32'(m_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async reset m_valid", 32'(m_valid), 32'd0);
    check("async reset s_ready", 32'(s_ready), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset grant", 32'(grant), 32'd3);
    for (int r = 0; r < N; r++) req_q[r].delete();
    s_valid = '0;
    s_last  = '0;
    @(negedge clk);
    rst = 1'b1;
    out_q.delete();
    exp_q.delete();
    push_pkt(3, 8'h73, 1, 1'b1);
    push_pkt(2, 8'h72, 1, 1'b1);
    expect_seq(2, 8'h72, 1);
    expect_seq(3, 8'h73, 1);
    run(1'b0, -1, 0, 100);
    compare_out("after reset");

    // Lone single-byte packet from requester 2 (header first when enabled).
    push_pkt(2, 8'h5A, 1, 1'b1);
    expect_seq(2, 8'h5A, 1);
    run(1'b0, -1, 0, 100);
    compare_out("single 5A");
    check("single 5A grant", 32'(grant), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
